// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: power-up clearing sweep, queued branch-resolution updates
// (read-modify-write on the shared read port) and LRU way replacement.
// Optional update statistics counters are built when BTB_STATS_EN is defined.
module btb_update_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETS       = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush,
  input  logic        fetch_rd_req,
  input  logic [6:0]  fetch_index,
  output logic [6:0]  btb_rd_index,
  input  logic [44:0] btb_rd_data1,
  input  logic [44:0] btb_rd_data2,
  output logic        btb_wr_en,
  output logic        btb_wr_way,
  output logic [6:0]  btb_wr_index,
  output logic [44:0] btb_wr_data,
  output logic        init_busy,
  output logic [31:0] stat_hit_cnt,
  output logic [31:0] stat_alloc_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CMP, S_WR} state_t;

  function automatic logic [9:0] tag_of(input logic [31:0] pc);
    return {pc[25:21] ^ pc[20:16], pc[15:11] ^ pc[10:6]};
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  state_t       state;
  logic [7:0]   init_cnt;
  logic [SETS-1:0] lru;

  logic [6:0]   q_index  [FIFO_DEPTH];
  logic [9:0]   q_tag    [FIFO_DEPTH];
  logic [31:0]  q_target [FIFO_DEPTH];
  logic         q_taken  [FIFO_DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         fifo_empty, fifo_full, push, pop;

  logic [6:0]   wk_index;
  logic [9:0]   wk_tag;
  logic [31:0]  wk_target;
  logic         wk_taken;

  logic         hit1, hit2, cmp_hit, cmp_way;
  logic [44:0]  old_entry, cmp_data;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{upd_pc[31:26], upd_pc[1:0]};

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign upd_ready  = ~init_busy & ~fifo_full;
  assign push       = upd_valid & upd_ready & ~flush;
  assign pop        = (state == S_IDLE) & ~fifo_empty & ~flush;

  // Fetch always wins the read port; the controller only drives it while in RD.
  assign btb_rd_index = (!fetch_rd_req && state == S_RD) ? wk_index : fetch_index;

  // Hit/victim selection and the new entry for the CMP cycle.
  always_comb begin
    hit1      = btb_rd_data1[44] && (btb_rd_data1[43:34] == wk_tag);
    hit2      = btb_rd_data2[44] && (btb_rd_data2[43:34] == wk_tag);
    cmp_hit   = hit1 | hit2;
    old_entry = hit1 ? btb_rd_data1 : btb_rd_data2;
    cmp_way   = 1'b0;
    cmp_data  = 45'd0;
    if (cmp_hit) begin
      cmp_way  = ~hit1;
      cmp_data = {1'b1, wk_tag,
                  wk_taken ? wk_target : old_entry[33:2],
                  wk_taken ? sat_inc(old_entry[1:0]) : sat_dec(old_entry[1:0])};
    end else begin
      if (!btb_rd_data1[44]) begin
        cmp_way = 1'b0;
      end else if (!btb_rd_data2[44]) begin
        cmp_way = 1'b1;
      end else begin
        cmp_way = lru[wk_index];
      end
      cmp_data = {1'b1, wk_tag, wk_target, 2'b10};
    end
  end

  // Update request FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      q_index[wptr[AW-1:0]]  <= upd_pc[8:2];
      q_tag[wptr[AW-1:0]]    <= tag_of(upd_pc);
      q_target[wptr[AW-1:0]] <= upd_target;
      q_taken[wptr[AW-1:0]]  <= upd_taken;
    end
  end

  // FIFO pointers; flush discards everything queued, including a same-cycle push.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Main sequencer with registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_INIT;
      init_cnt     <= 8'd0;
      init_busy    <= 1'b1;
      lru          <= '0;
      btb_wr_en    <= 1'b0;
      btb_wr_way   <= 1'b0;
      btb_wr_index <= 7'd0;
      btb_wr_data  <= 45'd0;
      wk_index     <= 7'd0;
      wk_tag       <= 10'd0;
      wk_target    <= 32'd0;
      wk_taken     <= 1'b0;
    end else begin
      btb_wr_en <= 1'b0;
      case (state)
        S_INIT: begin
          btb_wr_en    <= 1'b1;
          btb_wr_way   <= init_cnt[0];
          btb_wr_index <= init_cnt[7:1];
          btb_wr_data  <= 45'd0;
          init_cnt     <= init_cnt + 8'd1;
          if (init_cnt == 8'(2 * SETS - 1)) begin
            init_busy <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (pop) begin
            wk_index  <= q_index[rptr[AW-1:0]];
            wk_tag    <= q_tag[rptr[AW-1:0]];
            wk_target <= q_target[rptr[AW-1:0]];
            wk_taken  <= q_taken[rptr[AW-1:0]];
            state     <= S_RD;
          end
        end
        S_RD: begin
          if (!fetch_rd_req) state <= S_CMP;
        end
        S_CMP: begin
          if (cmp_hit || wk_taken) begin
            btb_wr_en    <= 1'b1;
            btb_wr_way   <= cmp_way;
            btb_wr_index <= wk_index;
            btb_wr_data  <= cmp_data;
            state        <= S_WR;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WR: begin
          lru[wk_index] <= ~btb_wr_way;
          state         <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

`ifdef BTB_STATS_EN
  logic cmp_alloc;
  assign cmp_alloc = ~cmp_hit & wk_taken;

  // Hit and allocation counters, sampled in the compare cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hit_cnt   <= 32'd0;
      stat_alloc_cnt <= 32'd0;
    end else if (state == S_CMP) begin
      if (cmp_hit)   stat_hit_cnt   <= stat_hit_cnt + 32'd1;
      if (cmp_alloc) stat_alloc_cnt <= stat_alloc_cnt + 32'd1;
    end
  end
`else
  assign stat_hit_cnt   = 32'd0;
  assign stat_alloc_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl with a behavioural 2-way BTB array model.
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid, upd_ready, upd_taken, flush, fetch_rd_req;
  logic [31:0] upd_pc, upd_target;
  logic [6:0]  fetch_index, btb_rd_index, btb_wr_index;
  logic [44:0] btb_rd_data1, btb_rd_data2, btb_wr_data;
  logic        btb_wr_en, btb_wr_way, init_busy;
  logic [31:0] stat_hit_cnt, stat_alloc_cnt;

  logic [44:0] mem1 [128];
  logic [44:0] mem2 [128];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  btb_update_ctrl #(.FIFO_DEPTH(4), .SETS(128)) dut (
    .clk(clk), .reset(reset),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .flush(flush),
    .fetch_rd_req(fetch_rd_req), .fetch_index(fetch_index),
    .btb_rd_index(btb_rd_index), .btb_rd_data1(btb_rd_data1), .btb_rd_data2(btb_rd_data2),
    .btb_wr_en(btb_wr_en), .btb_wr_way(btb_wr_way), .btb_wr_index(btb_wr_index),
    .btb_wr_data(btb_wr_data), .init_busy(init_busy),
    .stat_hit_cnt(stat_hit_cnt), .stat_alloc_cnt(stat_alloc_cnt)
  );

  // Synchronous-read BTB arrays.
  always @(posedge clk) begin
    if (btb_wr_en) begin
      if (btb_wr_way) mem2[btb_wr_index] <= btb_wr_data;
      else            mem1[btb_wr_index] <= btb_wr_data;
    end
    btb_rd_data1 <= mem1[btb_rd_index];
    btb_rd_data2 <= mem2[btb_rd_index];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic tk, input logic exp_wr, input logic exp_way,
                           input logic [6:0] exp_idx, input logic [44:0] exp_data);
    int nwr = 0;
    int lat = 0;
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = tk;
    #1 chk({tag, "_ready"}, 64'(upd_ready), 64'd1);
    cyc();
    upd_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (btb_wr_en) begin
        nwr++;
        if (lat == 0) begin
          lat = i;
          chk({tag, "_way"}, 64'(btb_wr_way), 64'(exp_way));
          chk({tag, "_idx"}, 64'(btb_wr_index), 64'(exp_idx));
          chk({tag, "_data"}, 64'(btb_wr_data), 64'(exp_data));
        end
      end
      cyc();
    end
    chk({tag, "_nwr"}, 64'(nwr), exp_wr ? 64'd1 : 64'd0);
    if (exp_wr) chk({tag, "_lat"}, 64'(lat), 64'd4);
  endtask

  initial begin
    int bad;
    int n;
    int nwr;
    int lat;
    reset = 1'b1; upd_valid = 1'b0; upd_pc = 32'd0; upd_target = 32'd0; upd_taken = 1'b0;
    flush = 1'b0; fetch_rd_req = 1'b0; fetch_index = 7'd0;
    cyc();
    reset = 1'b0;
    chk("rst_busy", 64'(init_busy), 64'd1);
    chk("rst_wr_en", 64'(btb_wr_en), 64'd0);
    chk("rst_ready", 64'(upd_ready), 64'd0);

    // Clearing sweep: one write per cycle, sets 0..127, way 0 then way 1.
    bad = 0;
    for (int k = 1; k <= 256; k++) begin
      fetch_rd_req = 1'b1;
      fetch_index = 7'(k);
      cyc();
      if (btb_wr_en !== 1'b1 || btb_wr_index !== 7'((k - 1) >> 1) ||
          btb_wr_way !== 1'((k - 1) & 1) || btb_wr_data !== 45'd0 ||
          upd_ready !== (k == 256) || init_busy !== (k < 256)) bad++;
    end
    fetch_rd_req = 1'b0;
    chk("init_sweep", 64'(bad), 64'd0);
    cyc();
    chk("init_done_wr", 64'(btb_wr_en), 64'd0);
    chk("init_done_ready", 64'(upd_ready), 64'd1);
    chk("init_done_busy", 64'(init_busy), 64'd0);

    // Allocation and LRU replacement in set 0x10.
    do_update("alloc1", 32'h0000_0040, 32'h0000_1000, 1'b1, 1'b1, 1'b0, 7'h10,
              {1'b1, 10'h001, 32'h0000_1000, 2'b10});
    do_update("alloc2", 32'h0001_0040, 32'h0000_2000, 1'b1, 1'b1, 1'b1, 7'h10,
              {1'b1, 10'h021, 32'h0000_2000, 2'b10});
    do_update("alloc3_lru", 32'h0002_0040, 32'h0000_3000, 1'b1, 1'b1, 1'b0, 7'h10,
              {1'b1, 10'h041, 32'h0000_3000, 2'b10});

    // Not-taken hits: counter decrements and saturates at 00, target kept.
    do_update("nt_hit1", 32'h0002_0040, 32'hDEAD_0000, 1'b0, 1'b1, 1'b0, 7'h10,
              {1'b1, 10'h041, 32'h0000_3000, 2'b01});
    do_update("nt_hit2", 32'h0002_0040, 32'hDEAD_0000, 1'b0, 1'b1, 1'b0, 7'h10,
              {1'b1, 10'h041, 32'h0000_3000, 2'b00});
    do_update("nt_hit3", 32'h0002_0040, 32'hDEAD_0000, 1'b0, 1'b1, 1'b0, 7'h10,
              {1'b1, 10'h041, 32'h0000_3000, 2'b00});

    // Taken hits on way 1: target replaced, counter saturates at 11.
    do_update("tk_hit1", 32'h0001_0040, 32'h0000_4444, 1'b1, 1'b1, 1'b1, 7'h10,
              {1'b1, 10'h021, 32'h0000_4444, 2'b11});
    do_update("tk_hit2", 32'h0001_0040, 32'h0000_4448, 1'b1, 1'b1, 1'b1, 7'h10,
              {1'b1, 10'h021, 32'h0000_4448, 2'b11});

    do_update("nt_miss", 32'h0004_0040, 32'h0000_5000, 1'b0, 1'b0, 1'b0, 7'h10, 45'd0);

    // Fetch contention: the update waits in RD while fetch owns the read port.
    upd_valid = 1'b1; upd_pc = 32'h0004_0040; upd_target = 32'h0000_5000; upd_taken = 1'b1;
    cyc();
    upd_valid = 1'b0; fetch_rd_req = 1'b1; fetch_index = 7'h55;
    bad = 0;
    for (int j = 0; j < 5; j++) begin
      #1;
      if (btb_rd_index !== 7'h55 || btb_wr_en !== 1'b0) bad++;
      cyc();
    end
    chk("fetch_prio", 64'(bad), 64'd0);
    fetch_rd_req = 1'b0;
    #1 chk("rd_ctrl_index", 64'(btb_rd_index), 64'h10);
    cyc();
    chk("stall_wr_early", 64'(btb_wr_en), 64'd0);
    cyc();
    chk("stall_wr_en", 64'(btb_wr_en), 64'd1);
    chk("stall_wr_way", 64'(btb_wr_way), 64'd0);
    chk("stall_wr_data", 64'(btb_wr_data), 64'({1'b1, 10'h081, 32'h0000_5000, 2'b10}));
    cyc();
    chk("stall_wr_single", 64'(btb_wr_en), 64'd0);
    cyc();

    // Fill the FIFO behind a stalled update, then flush the queued ones.
    fetch_rd_req = 1'b1; fetch_index = 7'h33;
    upd_valid = 1'b1; upd_pc = 32'h0000_0080; upd_target = 32'h0000_6000; upd_taken = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && upd_ready; i++) begin
      cyc();
      n++;
      upd_pc = 32'h0000_0080 + 32'(n * 4);
    end
    chk("fill_pushes", 64'(n), 64'd5);
    chk("full_ready", 64'(upd_ready), 64'd0);
    upd_valid = 1'b0; flush = 1'b1;
    cyc();
    upd_valid = 1'b1; upd_pc = 32'h0000_0200;
    #1 chk("flushed_ready", 64'(upd_ready), 64'd1);
    cyc();
    upd_valid = 1'b0; flush = 1'b0; fetch_rd_req = 1'b0;
    nwr = 0; lat = 0;
    for (int i = 0; i < 12; i++) begin
      if (btb_wr_en) begin
        nwr++;
        if (lat == 0) begin
          lat = i;
          chk("flush_wr_idx", 64'(btb_wr_index), 64'h20);
          chk("flush_wr_data", 64'(btb_wr_data), 64'({1'b1, 10'h002, 32'h0000_6000, 2'b10}));
        end
      end
      cyc();
    end
    chk("flush_nwr", 64'(nwr), 64'd1);
    chk("flush_lat", 64'(lat), 64'd2);

    // Reset during WR restarts the clearing sweep at set 0.
    upd_valid = 1'b1; upd_pc = 32'h0000_0100; upd_target = 32'h0000_7000; upd_taken = 1'b1;
    cyc();
    upd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (btb_wr_en) break;
      cyc();
    end
    chk("midwr_seen", 64'(btb_wr_en), 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midwr_rst_wr", 64'(btb_wr_en), 64'd0);
    chk("midwr_rst_busy", 64'(init_busy), 64'd1);
    chk("midwr_rst_ready", 64'(upd_ready), 64'd0);
    cyc();
    chk("reinit_wr0", 64'({btb_wr_en, btb_wr_way, btb_wr_index, btb_wr_data}),
        64'({1'b1, 1'b0, 7'd0, 45'd0}));
    cyc();
    chk("reinit_wr1", 64'({btb_wr_en, btb_wr_way, btb_wr_index, btb_wr_data}),
        64'({1'b1, 1'b1, 7'd0, 45'd0}));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
